// File: rtl/bcp_pkg.sv
// Shared types for the sequential BCP processing element.
// lit_t / clause_t describe the default 11-bit, 3-literal configuration;
// the modules themselves size their vectors from their own parameters.
package bcp_pkg;

    localparam int DEF_LIT_W   = 11;
    localparam int DEF_CLA_LEN = 3;

    typedef logic signed [DEF_LIT_W-1:0] lit_t;
    typedef lit_t [DEF_CLA_LEN-1:0]      clause_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        HALT = 2'd3
    } state_e;

endpackage

// File: rtl/bcp_clause_eval.sv
// Combinational evaluation of one clause against a decision literal:
// prunes literals equal to -dec and classifies the result.
module bcp_clause_eval #(
    parameter int LIT_W   = 11,
    parameter int CLA_LEN = 3
) (
    input  logic [CLA_LEN*LIT_W-1:0] clause_i,
    input  logic [LIT_W-1:0]         dec_i,
    output logic [CLA_LEN*LIT_W-1:0] pruned_o,
    output logic                     sat_o,
    output logic                     conflict_o,
    output logic                     unit_o,
    output logic [LIT_W-1:0]         unit_lit_o
);

    localparam int CNT_W = $clog2(CLA_LEN + 1) + 1;

    logic [LIT_W-1:0] negDec;
    logic [CNT_W-1:0] liveCount;

    assign negDec = -dec_i;

    // Mark satisfaction, zero falsified literals, then count what is left alive.
    always_comb begin
        sat_o      = 1'b0;
        pruned_o   = clause_i;
        liveCount  = '0;
        unit_lit_o = '0;
        for (int i = 0; i < CLA_LEN; i++) begin
            if (clause_i[i*LIT_W +: LIT_W] == dec_i) begin
                sat_o = 1'b1;
            end
            if (clause_i[i*LIT_W +: LIT_W] == negDec) begin
                pruned_o[i*LIT_W +: LIT_W] = '0;
            end
        end
        for (int i = 0; i < CLA_LEN; i++) begin
            if (pruned_o[i*LIT_W +: LIT_W] != '0) begin
                liveCount  = liveCount + CNT_W'(1);
                unit_lit_o = pruned_o[i*LIT_W +: LIT_W];
            end
        end
    end

    assign conflict_o = !sat_o && (liveCount == '0);
    assign unit_o     = !sat_o && (liveCount == CNT_W'(1));

endmodule

// File: rtl/bcp_pe_seq.sv
// Sequential Boolean constraint propagation element: loads clauses into a
// local store, then scans them one per cycle against each decision literal,
// emitting implications and halting on conflict.
// Optional feature: define BCP_PE_SEQ_STATS_EN to add the saturating
// 16-bit imp_total implication counter port.
module bcp_pe_seq
    import bcp_pkg::*;
#(
    parameter int LIT_W   = 11,
    parameter int CLA_LEN = 3,
    parameter int DEPTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     cla_valid,
    output logic                     cla_ready,
    input  logic [CLA_LEN*LIT_W-1:0] cla_in,
    input  logic                     dec_valid,
    output logic                     dec_ready,
    input  logic [LIT_W-1:0]         dec_lit,
    output logic                     imp_valid,
    input  logic                     imp_ready,
    output logic [LIT_W-1:0]         imp_lit,
    output logic                     busy,
    output logic                     sat,
    output logic                     conflict,
    output logic [$clog2(DEPTH):0]   cla_count
`ifdef BCP_PE_SEQ_STATS_EN
    ,
    output logic [15:0]              imp_total
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [CLA_LEN*LIT_W-1:0] clauseVec_t;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [IW-1:0]    scanIdx_q, scanIdx_d;
    logic [DEPTH-1:0] satMarks_q, satMarks_d;
    logic [LIT_W-1:0] decLit_q, decLit_d;
    logic [LIT_W-1:0] impLit_q, impLit_d;
    logic             sat_q, sat_d;
    logic             conflict_q, conflict_d;

    clauseVec_t       store_q [DEPTH];
    logic             storeWe;
    logic [IW-1:0]    storeAddr;
    clauseVec_t       storeData;

    clauseVec_t       curClause, prunedClause;
    logic             evalSat, evalConflict, evalUnit;
    logic [LIT_W-1:0] evalUnitLit;

    logic [DEPTH-1:0] loadedMask;
    logic             claFire, decFire, lastSlot, advance, finishScan;

    assign curClause = store_q[scanIdx_q];

    bcp_clause_eval #(
        .LIT_W   (LIT_W),
        .CLA_LEN (CLA_LEN)
    ) u_eval (
        .clause_i   (curClause),
        .dec_i      (decLit_q),
        .pruned_o   (prunedClause),
        .sat_o      (evalSat),
        .conflict_o (evalConflict),
        .unit_o     (evalUnit),
        .unit_lit_o (evalUnitLit)
    );

    assign cla_ready = (state_q == IDLE) && (count_q < CW'(DEPTH)) && !clear;
    // A clause load wins over a simultaneous decision, so the decision is held off.
    assign dec_ready = (state_q == IDLE) && (count_q != '0) && !clear
                       && !(cla_valid && cla_ready);
    assign claFire   = cla_valid && cla_ready;
    assign decFire   = dec_valid && dec_ready;
    assign imp_valid = (state_q == EMIT);
    assign imp_lit   = impLit_q;
    assign busy      = (state_q == SCAN) || (state_q == EMIT);
    assign sat       = sat_q;
    assign conflict  = conflict_q;
    assign cla_count = count_q;
    assign lastSlot  = (CW'(scanIdx_q) == (count_q - CW'(1)));

    // Which slots currently hold a loaded clause.
    always_comb begin
        loadedMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            loadedMask[i] = (CW'(i) < count_q);
        end
    end

    // Next-state logic: load, decision accept, per-slot scan, emit and halt.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        scanIdx_d  = scanIdx_q;
        satMarks_d = satMarks_q;
        decLit_d   = decLit_q;
        impLit_d   = impLit_q;
        sat_d      = sat_q;
        conflict_d = conflict_q;
        storeWe    = 1'b0;
        storeAddr  = scanIdx_q;
        storeData  = prunedClause;
        advance    = 1'b0;
        finishScan = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (claFire) begin
                    storeWe   = 1'b1;
                    storeAddr = count_q[IW-1:0];
                    storeData = cla_in;
                    count_d   = count_q + CW'(1);
                    sat_d     = 1'b0;
                end else if (decFire) begin
                    decLit_d  = dec_lit;
                    scanIdx_d = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (decLit_q == '0) begin
                    state_d = IDLE;
                end else if (satMarks_q[scanIdx_q]) begin
                    advance = 1'b1;
                end else begin
                    storeWe = 1'b1;
                    if (evalSat) begin
                        satMarks_d[scanIdx_q] = 1'b1;
                        advance               = 1'b1;
                    end else if (evalConflict) begin
                        conflict_d = 1'b1;
                        state_d    = HALT;
                    end else if (evalUnit) begin
                        impLit_d = evalUnitLit;
                        state_d  = EMIT;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (imp_ready) begin
                    advance = 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            if (lastSlot) begin
                state_d    = IDLE;
                finishScan = 1'b1;
            end else begin
                scanIdx_d = scanIdx_q + IW'(1);
                state_d   = SCAN;
            end
        end

        if (finishScan) begin
            sat_d = &(satMarks_d | ~loadedMask);
        end

        if (clear) begin
            state_d    = IDLE;
            count_d    = '0;
            satMarks_d = '0;
            sat_d      = 1'b0;
            conflict_d = 1'b0;
            impLit_d   = '0;
            storeWe    = 1'b0;
        end
    end

    // Control and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            scanIdx_q  <= '0;
            satMarks_q <= '0;
            decLit_q   <= '0;
            impLit_q   <= '0;
            sat_q      <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            scanIdx_q  <= scanIdx_d;
            satMarks_q <= satMarks_d;
            decLit_q   <= decLit_d;
            impLit_q   <= impLit_d;
            sat_q      <= sat_d;
            conflict_q <= conflict_d;
        end
    end

    // Clause store: not reset, slots become meaningful only once loaded.
    always_ff @(posedge clk) begin
        if (storeWe) begin
            store_q[storeAddr] <= storeData;
        end
    end

`ifdef BCP_PE_SEQ_STATS_EN
    logic [15:0] impTotal_q;

    // Saturating count of implication transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            impTotal_q <= '0;
        end else if (clear) begin
            impTotal_q <= '0;
        end else if (imp_valid && imp_ready && (impTotal_q != 16'hFFFF)) begin
            impTotal_q <= impTotal_q + 16'd1;
        end
    end

    assign imp_total = impTotal_q;
`endif

endmodule

// File: tb/tb_bcp_pe_seq.sv
// Self-checking bench for bcp_pe_seq: directed vector table, multi-cycle
// corner sequences and randomized decisions against a clause-level model.
module tb_bcp_pe_seq;

    localparam int LIT_W   = 11;
    localparam int CLA_LEN = 3;
    localparam int DEPTH   = 16;
    localparam int CW      = $clog2(DEPTH) + 1;

    localparam int K_SAT  = 0;
    localparam int K_NONE = 1;
    localparam int K_UNIT = 2;
    localparam int K_CONF = 3;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     clear = 1'b0;
    logic                     cla_valid = 1'b0;
    logic                     cla_ready;
    logic [CLA_LEN*LIT_W-1:0] cla_in = '0;
    logic                     dec_valid = 1'b0;
    logic                     dec_ready;
    logic [LIT_W-1:0]         dec_lit = '0;
    logic                     imp_valid;
    logic                     imp_ready = 1'b0;
    logic [LIT_W-1:0]         imp_lit;
    logic                     busy;
    logic                     sat;
    logic                     conflict;
    logic [CW-1:0]            cla_count;
`ifdef BCP_PE_SEQ_STATS_EN
    logic [15:0]              imp_total;
`endif

    bcp_pe_seq #(
        .LIT_W   (LIT_W),
        .CLA_LEN (CLA_LEN),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .cla_valid (cla_valid),
        .cla_ready (cla_ready),
        .cla_in    (cla_in),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_lit   (dec_lit),
        .imp_valid (imp_valid),
        .imp_ready (imp_ready),
        .imp_lit   (imp_lit),
        .busy      (busy),
        .sat       (sat),
        .conflict  (conflict),
        .cla_count (cla_count)
`ifdef BCP_PE_SEQ_STATS_EN
        ,
        .imp_total (imp_total)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: clause contents, satisfied marks, fill level.
    int mc [DEPTH][CLA_LEN];
    bit mm [DEPTH];
    int mCount;
    bit mSat;
    int expQ [$];

    typedef struct {
        int a;
        int b;
        int c;
        int dec;
        int kind;
        int lit;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: bound expired or unexpected event", name);
    endtask

    function automatic int litOf(input logic [LIT_W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [CLA_LEN*LIT_W-1:0] packClause(input int a, input int b, input int c);
        logic [CLA_LEN*LIT_W-1:0] r;
        r = {LIT_W'(c), LIT_W'(b), LIT_W'(a)};
        return r;
    endfunction

    task automatic applyStimulus(input int a, input int b, input int c);
        int n = 0;
        cla_in    = packClause(a, b, c);
        cla_valid = 1'b1;
        #1;
        while (!cla_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) failNow("claLoadTimeout");
        @(posedge clk); #1;
        cla_valid = 1'b0;
    endtask

    task automatic applyDecision(input int d);
        int n = 0;
        dec_lit   = LIT_W'(d);
        dec_valid = 1'b1;
        #1;
        while (!dec_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) failNow("decTimeout");
        @(posedge clk); #1;
        dec_valid = 1'b0;
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        #1;
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) failNow("idleTimeout");
    endtask

    // Clause-level model of one decision: which slots are looked at, which
    // units come out in order, and whether a conflict ends the pass.
    task automatic modelDecide(input int d, output int nScan, output bit conf);
        bit hit;
        int live;
        int lastLive;
        conf  = 1'b0;
        nScan = 0;
        if (d == 0) begin
            nScan = 1;
            return;
        end
        for (int s = 0; s < mCount; s++) begin
            nScan++;
            if (mm[s]) continue;
            hit = 1'b0;
            for (int k = 0; k < CLA_LEN; k++) if (mc[s][k] == d) hit = 1'b1;
            for (int k = 0; k < CLA_LEN; k++) if (mc[s][k] == -d) mc[s][k] = 0;
            if (hit) begin
                mm[s] = 1'b1;
                continue;
            end
            live     = 0;
            lastLive = 0;
            for (int k = 0; k < CLA_LEN; k++) begin
                if (mc[s][k] != 0) begin
                    live++;
                    lastLive = mc[s][k];
                end
            end
            if (live == 0) begin
                conf = 1'b1;
                return;
            end
            if (live == 1) expQ.push_back(lastLive);
        end
        mSat = 1'b1;
        for (int s = 0; s < mCount; s++) if (!mm[s]) mSat = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int d;
        int expScan;
        bit expConf;
        int scanCyc;
        int rdy;

        vecs[0]  = '{3, -5, 7, 3, K_SAT, 0};
        vecs[1]  = '{2, -4, 0, 4, K_UNIT, 2};
        vecs[2]  = '{-6, 0, 0, 6, K_CONF, 0};
        vecs[3]  = '{1, 2, 3, 9, K_NONE, 0};
        vecs[4]  = '{1, 2, 0, -1, K_UNIT, 2};
        vecs[5]  = '{5, 0, 0, 7, K_UNIT, 5};
        vecs[6]  = '{0, 0, 0, 3, K_CONF, 0};
        vecs[7]  = '{-8, 8, 0, 8, K_SAT, 0};
        vecs[8]  = '{4, -4, 9, -4, K_SAT, 0};
        vecs[9]  = '{7, 7, 3, -7, K_UNIT, 3};
        vecs[10] = '{-1023, 5, -5, 1023, K_NONE, 0};
        vecs[11] = '{1023, 0, 0, -1023, K_CONF, 0};

        // Reset values while rst_n is held low.
        #3;
        checkOutput("rstClaReady", int'(cla_ready), 1);
        checkOutput("rstDecReady", int'(dec_ready), 0);
        checkOutput("rstImpValid", int'(imp_valid), 0);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstSat", int'(sat), 0);
        checkOutput("rstConflict", int'(conflict), 0);
        checkOutput("rstCount", int'(cla_count), 0);
        checkOutput("rstImpLit", int'(imp_lit), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-clause vector table.
        for (int v = 0; v < 12; v++) begin
            pulseClear();
            applyStimulus(vecs[v].a, vecs[v].b, vecs[v].c);
            applyDecision(vecs[v].dec);
            checkOutput($sformatf("v%0d_busyScan", v), int'(busy), 1);
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d_sat", v), int'(sat), int'(vecs[v].kind == K_SAT));
            checkOutput($sformatf("v%0d_conflict", v), int'(conflict), int'(vecs[v].kind == K_CONF));
            checkOutput($sformatf("v%0d_impValid", v), int'(imp_valid), int'(vecs[v].kind == K_UNIT));
            checkOutput($sformatf("v%0d_busy", v), int'(busy), int'(vecs[v].kind == K_UNIT));
            checkOutput($sformatf("v%0d_decReady", v), int'(dec_ready),
                        int'(vecs[v].kind == K_SAT || vecs[v].kind == K_NONE));
            if (vecs[v].kind == K_UNIT) begin
                checkOutput($sformatf("v%0d_impLit", v), litOf(imp_lit), vecs[v].lit);
                imp_ready = 1'b1;
                @(posedge clk); #1;
                imp_ready = 1'b0;
                checkOutput($sformatf("v%0d_afterEmitBusy", v), int'(busy), 0);
            end
        end

        // Implication held while the consumer stalls.
        pulseClear();
        applyStimulus(2, -4, 0);
        applyDecision(4);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stallImpValid", int'(imp_valid), 1);
            checkOutput("stallImpLit", litOf(imp_lit), 2);
            @(posedge clk); #1;
        end
        imp_ready = 1'b1;
        @(posedge clk); #1;
        imp_ready = 1'b0;
        checkOutput("stallDoneBusy", int'(busy), 0);
        checkOutput("stallDoneValid", int'(imp_valid), 0);

        // Conflict halts until clear.
        pulseClear();
        applyStimulus(-6, 0, 0);
        applyDecision(6);
        @(posedge clk); #1;
        checkOutput("haltConflict", int'(conflict), 1);
        dec_lit   = LIT_W'(1);
        dec_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("haltDecReady", int'(dec_ready), 0);
            checkOutput("haltClaReady", int'(cla_ready), 0);
            @(posedge clk); #1;
        end
        dec_valid = 1'b0;
        checkOutput("haltStillConflict", int'(conflict), 1);
        pulseClear();
        checkOutput("clearCount", int'(cla_count), 0);
        checkOutput("clearConflict", int'(conflict), 0);
        checkOutput("clearClaReady", int'(cla_ready), 1);

        // Full store, extra load ignored, scan takes one cycle per slot.
        for (int i = 0; i < DEPTH; i++) applyStimulus(i + 1, i + 20, -(i + 40));
        checkOutput("fullCount", int'(cla_count), DEPTH);
        checkOutput("fullClaReady", int'(cla_ready), 0);
        cla_in    = packClause(100, 0, 0);
        cla_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cla_valid = 1'b0;
        checkOutput("fullCountHeld", int'(cla_count), DEPTH);
        applyDecision(100);
        waitIdle(n);
        checkOutput("fullScanCycles", n, DEPTH);
        checkOutput("fullSat", int'(sat), 0);

        // Zero decision is discarded after a single busy cycle.
        pulseClear();
        applyStimulus(1, 2, 3);
        applyDecision(0);
        checkOutput("zeroDecBusy", int'(busy), 1);
        @(posedge clk); #1;
        checkOutput("zeroDecIdle", int'(busy), 0);
        checkOutput("zeroDecSat", int'(sat), 0);
        applyDecision(2);
        waitIdle(n);
        checkOutput("afterZeroSat", int'(sat), 1);

        // Simultaneous clause and decision: clause first.
        pulseClear();
        applyStimulus(1, 2, 3);
        cla_in    = packClause(4, 5, 6);
        cla_valid = 1'b1;
        dec_lit   = LIT_W'(4);
        dec_valid = 1'b1;
        #1;
        checkOutput("bothDecReady", int'(dec_ready), 0);
        checkOutput("bothClaReady", int'(cla_ready), 1);
        @(posedge clk); #1;
        cla_valid = 1'b0;
        #1;
        checkOutput("bothCount", int'(cla_count), 2);
        checkOutput("bothNotBusy", int'(busy), 0);
        @(posedge clk); #1;
        dec_valid = 1'b0;
        checkOutput("bothDecTaken", int'(busy), 1);
        waitIdle(n);
        checkOutput("bothScanCycles", n, 2);
        checkOutput("bothSat", int'(sat), 0);

        // Asynchronous reset while emitting.
        pulseClear();
        applyStimulus(2, -4, 0);
        applyDecision(4);
        @(posedge clk); #1;
        checkOutput("preRstImpValid", int'(imp_valid), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstImpValid", int'(imp_valid), 0);
        checkOutput("midRstBusy", int'(busy), 0);
        checkOutput("midRstCount", int'(cla_count), 0);
        checkOutput("midRstClaReady", int'(cla_ready), 1);
        checkOutput("midRstDecReady", int'(dec_ready), 0);
        checkOutput("midRstImpLit", int'(imp_lit), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized decisions against the clause-level model.
        for (int r = 0; r < 25; r++) begin
            pulseClear();
            mCount = $urandom_range(1, 8);
            mSat   = 1'b0;
            for (int s = 0; s < mCount; s++) begin
                for (int k = 0; k < CLA_LEN; k++) mc[s][k] = int'($urandom_range(0, 12)) - 6;
                mm[s] = 1'b0;
                applyStimulus(mc[s][0], mc[s][1], mc[s][2]);
            end
            checkOutput("rndCount", int'(cla_count), mCount);
            for (int t = 0; t < 6; t++) begin
                d = int'($urandom_range(0, 12)) - 6;
                expQ.delete();
                modelDecide(d, expScan, expConf);
                applyDecision(d);
                n       = 0;
                scanCyc = 0;
                while (busy && n < 300) begin
                    rdy = 0;
                    if (imp_valid) begin
                        if (expQ.size() == 0) failNow("rndUnexpectedImp");
                        else checkOutput("rndImpLit", litOf(imp_lit), expQ[0]);
                        rdy       = int'($urandom_range(0, 1));
                        imp_ready = (rdy != 0);
                    end else begin
                        scanCyc++;
                    end
                    @(posedge clk); #1;
                    imp_ready = 1'b0;
                    if (rdy != 0 && expQ.size() != 0) void'(expQ.pop_front());
                    n++;
                end
                if (n >= 300) failNow("rndTimeout");
                checkOutput("rndMissingImp", expQ.size(), 0);
                checkOutput("rndScanCycles", scanCyc, expScan);
                checkOutput("rndConflict", int'(conflict), int'(expConf));
                if (expConf) begin
                    checkOutput("rndHaltDecReady", int'(dec_ready), 0);
                    break;
                end
                checkOutput("rndSat", int'(sat), int'(mSat));
            end
        end

`ifdef BCP_PE_SEQ_STATS_EN
        // Implication counter over three unit-producing clauses.
        pulseClear();
        checkOutput("statsCleared", int'(imp_total), 0);
        applyStimulus(1, -9, 0);
        applyStimulus(2, -9, 0);
        applyStimulus(3, -9, 0);
        applyDecision(9);
        imp_ready = 1'b1;
        waitIdle(n);
        imp_ready = 1'b0;
        checkOutput("statsTotal", int'(imp_total), 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcp_pe_seq.md
BCP_PE_SEQ -- requirements
Module: bcp_pe_seq

Interface
REQ-001 SHALL have parameter LIT_W, default 11, meaning literal width; signed two's complement; value 0 reserved as "pruned".
REQ-002 SHALL have parameter CLA_LEN, default 3, meaning literals per clause.
REQ-003 SHALL have parameter DEPTH, default 16, meaning the number of clause slots in the local store.
REQ-004 SHALL have port clk, input, 1, meaning the single clock.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-006 SHALL have ports cla_valid (input, 1), cla_ready (output, 1) and cla_in (input, CLA_LEN*LIT_W), meaning clause load handshake.
REQ-007 SHALL have ports dec_valid (input, 1), dec_ready (output, 1) and dec_lit (input, LIT_W), meaning decision literal handshake.
REQ-008 SHALL have ports imp_valid (output, 1), imp_ready (input, 1) and imp_lit (output, LIT_W), meaning implication output handshake.
REQ-009 SHALL have output ports busy (1), sat (1), conflict (1) and cla_count (clog2(DEPTH)+1).
REQ-010 SHALL have input port clear (1), meaning synchronous flush of the store and all flags.

Function
REQ-011 SHALL transfer on any handshake only when valid and ready are both high at the rising clk edge.
REQ-012 SHALL implement FSM states IDLE, SCAN, EMIT and HALT.
REQ-013 SHALL, in IDLE, assert cla_ready whenever cla_count < DEPTH; on each transfer, write the clause to slot cla_count and increment cla_count.
REQ-014 SHALL, when cla_count == DEPTH, deassert cla_ready; no overwrite or wrap-around occurs.
REQ-015 SHALL assert dec_ready only in IDLE with cla_count > 0.
REQ-016 SHALL, if cla_valid and dec_valid are both high in IDLE, accept the clause load only; the decision waits one cycle.
REQ-017 SHALL, on decision accept, latch dec_lit, enter SCAN and set scan index 0.
REQ-018 SHALL discard a latched decision literal of 0: no state change, and the FSM returns to IDLE next cycle.
REQ-019 SHALL, in SCAN, evaluate one slot per cycle:
- any literal equal to dec: mark slot satisfied;
- any literal equal to -dec: zero that literal in place.
REQ-020 SHALL skip slots already marked satisfied; they are not evaluated or modified.
REQ-021 SHALL treat an unsatisfied slot whose pruned literals are all zero as a conflict: set conflict and enter HALT.
REQ-022 SHALL treat an unsatisfied slot with exactly one nonzero literal as an implication: enter EMIT with imp_lit equal to that literal.
REQ-023 SHALL, in EMIT, hold imp_valid and imp_lit stable until imp_ready, then resume SCAN at the next slot; back-to-back emits are allowed.
REQ-024 SHALL return to IDLE after the last slot (cla_count-1); sat is 1 iff every loaded slot is marked satisfied.
REQ-025 SHALL take scan latency of cla_count cycles plus one cycle per emitted implication plus any imp_ready stall cycles.
REQ-026 SHALL hold busy high in SCAN and EMIT.
REQ-027 SHALL remain in HALT until clear.
REQ-028 SHALL give clear priority over all other activity: cla_count=0, all satisfied marks=0, conflict=0, sat=0, next state IDLE.
REQ-029 SHALL compute negation at LIT_W bits; -(most-negative) is outside the legal literal range and its behaviour is unspecified.

Reset
REQ-030 SHALL, on rst_n low (any state, including mid-SCAN/EMIT), immediately force:
- state IDLE; cla_count=0; satisfied marks cleared;
- imp_valid=0, busy=0, sat=0, conflict=0;
- imp_lit=0, cla_ready=1, dec_ready=0.
REQ-031 SHALL not reset clause store contents; slots are invalid until reloaded.

Configuration
REQ-032 SHALL implement macro BCP_PE_SEQ_STATS_EN: when defined, add output port imp_total (16-bit, saturating), incremented on each implication transfer and cleared by reset/clear.
REQ-033 SHALL, when BCP_PE_SEQ_STATS_EN is undefined, have no port and no counter logic.

Structure
REQ-034 SHALL declare lit_t, clause_t (CLA_LEN x lit_t) and the FSM state enum in shared package bcp_pkg.
REQ-035 SHALL instantiate sub-module bcp_clause_eval (combinational: clause + dec -> pruned clause, sat, conflict, unit, unit_lit), one instance.

Verification
REQ-036 SHALL verify: load {3,-5,7}, dec=3 -> slot satisfied, sat=1, no imp_valid, back to IDLE after 1 scan cycle.
REQ-037 SHALL verify: load {2,-4,0}, dec=4 -> imp_valid with imp_lit=2; imp_ready held low 5 cycles -> imp_lit stable throughout.
REQ-038 SHALL verify: load {-6,0,0}, dec=6 -> conflict=1, HALT; dec_ready=0 until clear pulse, then cla_count=0.
REQ-039 SHALL verify: load DEPTH clauses -> cla_ready=0; an extra cla_valid is ignored; cla_count==DEPTH.
REQ-040 SHALL verify: rst_n low mid-EMIT -> imp_valid=0, busy=0, state IDLE, same cycle.
REQ-041 SHALL verify: with BCP_PE_SEQ_STATS_EN, 3 clauses each yielding a unit -> imp_total=3.
